mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width; the iteration count equals WIDTH.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  synchronous cancel of any in-flight operation.
REQ-006 SHALL have port op_high  input  1  0 = result is low WIDTH bits of product (MUL); 1 = high WIDTH bits, unsigned (UMULH).
REQ-007 SHALL have port OpA  input  WIDTH  multiplicand, driven from regfile ReadData1.
REQ-008 SHALL have port OpB  input  WIDTH  multiplier, driven from regfile ReadData2.
REQ-009 SHALL have port DestReg  input  5  destination register number.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight (BUSY or WB).
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port WriteData  output  WIDTH  result to the regfile write port.
REQ-013 SHALL have port WriteRegister  output  5  latched DestReg.
REQ-014 SHALL have port RegWrite  output  1  write enable to the regfile.

Function
REQ-015 SHALL implement three states: IDLE, BUSY, WB.
REQ-016 SHALL, in IDLE with start=1 and flush=0 at edge E0:
- latch OpA, OpB, op_high and DestReg;
- clear the 2*WIDTH-bit accumulator;
- load the iteration counter with 0;
- enter BUSY.
REQ-017 SHALL perform one radix-2 unsigned shift-add step per BUSY edge: if the current multiplier LSB = 1, add the shifted multiplicand into the accumulator; then shift; increment the counter.
REQ-018 SHALL transition BUSY to WB at the edge where the counter reaches WIDTH-1, i.e. edge E(WIDTH), with the full 2*WIDTH-bit product complete.
REQ-019 SHALL, in WB, present WriteData = product[WIDTH-1:0] (op_high=0) or product[2*WIDTH-1:WIDTH] (op_high=1), and assert done=1 for exactly that cycle.
REQ-020 SHALL assert RegWrite=1 in WB only if the latched DestReg != 31; register 31 always reads zero, so the write is suppressed while done still pulses.
REQ-021 SHALL return from WB to IDLE on the next edge, E(WIDTH+1).
REQ-022 SHALL give fixed latency: start sampled at E0, so RegWrite/done are high between E(WIDTH) and E(WIDTH+1); no early termination for zero operands.
REQ-023 SHALL drive busy=1 in BUSY and WB, and 0 in IDLE.
REQ-024 SHALL ignore start while busy=1; operands, DestReg and op_high SHALL remain the latched values.
REQ-025 SHALL hold RegWrite=0 and done=0 in IDLE and BUSY.
REQ-026 SHALL hold WriteData and WriteRegister stable (latched values) outside WB.
REQ-027 SHALL, on flush=1 at any edge, enter IDLE with no RegWrite or done pulse; flush outranks start when both are high in IDLE.
REQ-028 SHALL, on flush=1 in WB, cancel the write: RegWrite and done are 0 from the next edge onward; the current-cycle outputs are already committed.
REQ-029 SHALL allow back-to-back operations: start may be accepted in the IDLE cycle immediately after WB.
REQ-030 SHALL compute all arithmetic modulo 2^(2*WIDTH) with no overflow flag.

Reset
REQ-031 SHALL, on reset=0, asynchronously force:
- state = IDLE, counter = 0, accumulator = 0;
- busy = 0, done = 0, RegWrite = 0;
- WriteData = 0, WriteRegister = 0.
REQ-032 SHALL, on reset asserted mid-operation, discard the operation; no write occurs after release.
REQ-033 SHALL, after reset release, accept start at the first rising edge.

Verification
REQ-034 SHALL cover MUL: OpA=3, OpB=5, DestReg=2, op_high=0 -> RegWrite=1, WriteRegister=2, WriteData=15, exactly WIDTH edges after start.
REQ-035 SHALL cover UMULH: OpA=OpB=0xFFFF_FFFF_FFFF_FFFF, op_high=1 -> WriteData=0xFFFF_FFFF_FFFF_FFFE; with op_high=0 -> WriteData=0x1.
REQ-036 SHALL cover flush: start, then flush at BUSY cycle 30 -> busy=0 next cycle; no RegWrite or done pulse ever; a new start is accepted immediately.
REQ-037 SHALL cover start during busy: start with DestReg=4, second start with DestReg=7 at cycle 10 -> single write to register 4 only, with the first operands' product.
REQ-038 SHALL cover DestReg=31: OpA=2, OpB=2 -> done pulses once, RegWrite stays 0.
REQ-039 SHALL cover reset mid-operation: reset=0 at BUSY cycle 40, release -> all outputs 0, no write; a new start produces the correct product.

Source files
------------

// File: rtl/mult_unit.sv
// Iterative radix-2 unsigned shift-add multiplier with register-file writeback.
// One operand bit is consumed per BUSY cycle; the result is presented for a single WB cycle.
module mult_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic             op_high,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       DestReg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] WriteData,
    output logic [4:0]       WriteRegister,
    output logic             RegWrite
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 op_high_q;
    logic [4:0]           dest_q;
    logic [2*WIDTH-1:0]   acc_next;

    function automatic logic [WIDTH-1:0] select_half(input logic [2*WIDTH-1:0] prod,
                                                     input logic high);
        return high ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    endfunction

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Operand registers: loaded on acceptance, shifted once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !flush) begin
            mcand     <= {{WIDTH{1'b0}}, OpA};
            mplier    <= OpB;
            op_high_q <= op_high;
            dest_q    <= DestReg;
        end else if (state == BUSY) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Control, accumulator and registered writeback outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            acc           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            RegWrite      <= 1'b0;
            WriteData     <= '0;
            WriteRegister <= '0;
        end else if (flush) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            RegWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        // acc_next already holds the final partial product here.
                        state         <= WB;
                        done          <= 1'b1;
                        RegWrite      <= (dest_q != 5'd31);
                        WriteData     <= select_half(acc_next, op_high_q);
                        WriteRegister <= dest_q;
                    end
                end
                WB: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    RegWrite <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    RegWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: a driver queues expected writebacks, a monitor checks every done pulse.
module tb_mult_unit;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic             op_high = 1'b0;
    logic [WIDTH-1:0] OpA = '0;
    logic [WIDTH-1:0] OpB = '0;
    logic [4:0]       DestReg = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       WriteRegister;
    logic             RegWrite;

    mult_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op_high(op_high),
        .OpA(OpA), .OpB(OpB), .DestReg(DestReg), .busy(busy), .done(done),
        .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [4:0]       rd;
        logic             we;
        int unsigned      edge_no;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edges = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: full-width product by plain multiplication, then pick the half.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic hi);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return hi ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
    endfunction

    // Call at a negedge; returns 1 time unit after the accepting edge.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] rd, input logic hi, input bit expect_wb);
        exp_t e;
        OpA = a; OpB = b; DestReg = rd; op_high = hi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_wb) begin
            e.data    = model(a, b, hi);
            e.rd      = rd;
            e.we      = (rd != 5'd31);
            e.edge_no = edges + WIDTH;
            exp_q.push_back(e);
        end
    endtask

    // Returns at a negedge with busy low.
    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("regwrite_without_done", {127'b0, RegWrite & ~done}, 0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wb_data", WriteData, e.data);
                check("wb_reg", WriteRegister, e.rd);
                check("wb_regwrite", RegWrite, e.we);
                check("wb_latency", edges, e.edge_no);
                check("wb_busy", busy, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [4:0]       rrd;

        // Asynchronous reset state before any clock edge
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_wreg", WriteRegister, 0);

        // Start at the first edge after release: MUL 3*5 -> r2
        @(negedge clk);
        reset = 1'b1;
        do_op(64'd3, 64'd5, 5'd2, 1'b0, 1);
        check("busy_after_start", busy, 1);

        // UMULH and MUL of all-ones
        wait_idle();
        check("idle_outputs_done", done, 0);
        do_op({WIDTH{1'b1}}, {WIDTH{1'b1}}, 5'd9, 1'b1, 1);
        wait_idle();
        do_op({WIDTH{1'b1}}, {WIDTH{1'b1}}, 5'd10, 1'b0, 1);

        // Flush at BUSY cycle 30, then immediate restart
        wait_idle();
        do_op(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 5'd5, 1'b0, 0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        do_op(64'd7, 64'd6, 5'd6, 1'b0, 1);

        // Second start during busy must be ignored
        wait_idle();
        do_op(64'h1111, 64'h2222, 5'd4, 1'b0, 1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        OpA = 64'hdead; OpB = 64'hbeef; DestReg = 5'd7; op_high = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_hold_ignore", busy, 1);

        // Register 31: done pulses, write suppressed
        wait_idle();
        do_op(64'd2, 64'd2, 5'd31, 1'b0, 1);

        // Flush during WB: current-cycle pulse stands, nothing afterwards
        wait_idle();
        do_op(64'd100, 64'd200, 5'd12, 1'b0, 1);
        repeat (WIDTH) @(posedge clk);
        @(negedge clk);
        check("wb_done_before_flush", done, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("wbflush_done", done, 0);
        check("wbflush_regwrite", RegWrite, 0);
        check("wbflush_busy", busy, 0);

        // Reset at BUSY cycle 40, then a clean operation
        wait_idle();
        do_op(64'hffff_0000_ffff_0000, 64'h3, 5'd13, 1'b1, 0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_wdata", WriteData, 0);
        check("midrst_wreg", WriteRegister, 0);
        @(negedge clk);
        reset = 1'b1;
        do_op(64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 5'd14, 1'b1, 1);

        // Back-to-back: next start in the IDLE cycle right after WB
        wait_idle();
        do_op(64'd9, 64'd9, 5'd15, 1'b0, 1);
        repeat (WIDTH) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", busy, 0);
        do_op(64'd11, 64'd13, 5'd16, 1'b0, 1);

        // Randomized operations, including zero operands and register 31
        for (int i = 0; i < 24; i++) begin
            wait_idle();
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (i % 7 == 3) ra = '0;
            if (i % 5 == 2) rb = {WIDTH{1'b1}};
            rrd = 5'($urandom_range(0, 31));
            do_op(ra, rb, rrd, 1'($urandom_range(0, 1)), 1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
